// File: rtl/ili9341_pkg.sv
// Shared opcodes and receiver FSM encodings for the ILI9341 8080-style write bus.
package ili9341_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAM_HI,
    ST_RAM_LO,
    ST_SKIP
  } state_t;

  // Window coordinates are 16-bit on the bus but only 9 bits are meaningful.
  function automatic logic [8:0] trunc9(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[0], lo};
  endfunction

endpackage

// File: rtl/ili9341_cursor.sv
// Column/page window registers and the raster cursor that walks them.
// Loads, homing and advance take effect on the next clock edge.
module ili9341_cursor
  import ili9341_pkg::*;
#(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_defaults,
  input  logic       i_load_col,
  input  logic       i_load_row,
  input  logic [8:0] i_start_v,
  input  logic [8:0] i_end_v,
  input  logic       i_home,
  input  logic       i_advance,
  output logic [8:0] o_cur_x,
  output logic [8:0] o_cur_y
);

  localparam logic [8:0] EC_RST = 9'(WIDTH - 1);
  localparam logic [8:0] EP_RST = 9'(HEIGHT - 1);

  logic [8:0] r_sc, r_ec, r_sp, r_ep;
  logic [8:0] r_cx, r_cy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sc <= '0;
      r_ec <= EC_RST;
      r_sp <= '0;
      r_ep <= EP_RST;
      r_cx <= '0;
      r_cy <= '0;
    end else begin
      if (i_defaults) begin
        r_sc <= '0;
        r_ec <= EC_RST;
        r_sp <= '0;
        r_ep <= EP_RST;
      end else if (i_load_col) begin
        r_sc <= i_start_v;
        r_ec <= i_end_v;
      end else if (i_load_row) begin
        r_sp <= i_start_v;
        r_ep <= i_end_v;
      end

      if (i_home) begin
        r_cx <= r_sc;
        r_cy <= r_sp;
      end else if (i_advance) begin
        // Raster order: columns first, wrapping back to the window's top row.
        if (r_cx >= r_ec) begin
          r_cx <= r_sc;
          r_cy <= (r_cy >= r_ep) ? r_sp : r_cy + 9'd1;
        end else begin
          r_cx <= r_cx + 9'd1;
        end
      end
    end
  end

  assign o_cur_x = r_cx;
  assign o_cur_y = r_cy;

endmodule

// File: rtl/ili9341_rx.sv
// ILI9341 write-bus receiver: decodes command/data bytes, tracks the window and
// emits one addressed RGB565 pixel per data byte pair, one cycle after the low byte.
module ili9341_rx
  import ili9341_pkg::*;
#(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320
) (
  input  logic        clk_16MHz,
  input  logic        rst,
  input  logic        ncs,
  input  logic        cmd_data,
  input  logic        write_edge,
  input  logic [7:0]  din,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        cmd_strobe,
  output logic [7:0]  last_cmd,
  output logic        display_on,
  output logic        sleep_out
);

  state_t     r_state;
  logic       r_we_q;
  logic [1:0] r_arg_cnt;
  logic [7:0] r_arg0, r_arg1, r_arg2;
  logic [7:0] r_hi;

  logic       w_stb, w_cmd, w_dat;
  logic       w_home, w_defaults, w_load_col, w_load_row, w_advance;
  logic [8:0] w_start_v, w_end_v;
  logic [8:0] w_cur_x, w_cur_y;

  assign w_stb      = write_edge & ~r_we_q & ~ncs;
  assign w_cmd      = w_stb & ~cmd_data;
  assign w_dat      = w_stb & cmd_data;
  assign w_home     = w_cmd && (din == CMD_RAMWR);
  assign w_defaults = w_cmd && (din == CMD_SWRESET);
  assign w_load_col = w_dat && (r_state == ST_CASET) && (r_arg_cnt == 2'd3);
  assign w_load_row = w_dat && (r_state == ST_PASET) && (r_arg_cnt == 2'd3);
  assign w_advance  = w_dat && (r_state == ST_RAM_LO);
  assign w_start_v  = trunc9(r_arg0, r_arg1);
  assign w_end_v    = trunc9(r_arg2, din);

  ili9341_cursor #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_cursor (
    .clk       (clk_16MHz),
    .rst       (rst),
    .i_defaults(w_defaults),
    .i_load_col(w_load_col),
    .i_load_row(w_load_row),
    .i_start_v (w_start_v),
    .i_end_v   (w_end_v),
    .i_home    (w_home),
    .i_advance (w_advance),
    .o_cur_x   (w_cur_x),
    .o_cur_y   (w_cur_y)
  );

  always_ff @(posedge clk_16MHz or posedge rst) begin
    if (rst) begin
      r_we_q     <= 1'b0;
      r_state    <= ST_IDLE;
      r_arg_cnt  <= '0;
      r_arg0     <= '0;
      r_arg1     <= '0;
      r_arg2     <= '0;
      r_hi       <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      cmd_strobe <= 1'b0;
      last_cmd   <= 8'h00;
      display_on <= 1'b0;
      sleep_out  <= 1'b0;
    end else begin
      r_we_q     <= write_edge;
      pix_valid  <= 1'b0;
      cmd_strobe <= 1'b0;
      if (w_cmd) begin
        // Any command abandons a half-received pixel or argument list.
        cmd_strobe <= 1'b1;
        last_cmd   <= din;
        r_arg_cnt  <= '0;
        case (din)
          CMD_CASET: r_state <= ST_CASET;
          CMD_PASET: r_state <= ST_PASET;
          CMD_RAMWR: r_state <= ST_RAM_HI;
          CMD_DISPON: begin
            display_on <= 1'b1;
            r_state    <= ST_SKIP;
          end
          CMD_DISPOFF: begin
            display_on <= 1'b0;
            r_state    <= ST_SKIP;
          end
          CMD_SLPOUT: begin
            sleep_out <= 1'b1;
            r_state   <= ST_SKIP;
          end
          CMD_SLPIN: begin
            sleep_out <= 1'b0;
            r_state   <= ST_SKIP;
          end
          CMD_SWRESET: begin
            display_on <= 1'b0;
            sleep_out  <= 1'b0;
            r_state    <= ST_SKIP;
          end
          default: r_state <= ST_SKIP;
        endcase
      end else if (w_dat) begin
        case (r_state)
          ST_CASET, ST_PASET: begin
            r_arg_cnt <= r_arg_cnt + 2'd1;
            case (r_arg_cnt)
              2'd0:    r_arg0  <= din;
              2'd1:    r_arg1  <= din;
              2'd2:    r_arg2  <= din;
              default: r_state <= ST_IDLE;
            endcase
          end
          ST_RAM_HI: begin
            r_hi    <= din;
            r_state <= ST_RAM_LO;
          end
          ST_RAM_LO: begin
            pix_valid <= 1'b1;
            pix_x     <= w_cur_x;
            pix_y     <= w_cur_y;
            pix_data  <= {r_hi, din};
            r_state   <= ST_RAM_HI;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ili9341_rx.sv
// Directed plus randomized bench for ili9341_rx against a byte-level reference model.
`timescale 1ns/1ps
module tb_ili9341_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ncs = 1'b0;
  logic        cmd_data = 1'b0;
  logic        write_edge = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        pix_valid;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] pix_data;
  logic        cmd_strobe;
  logic [7:0]  last_cmd;
  logic        display_on, sleep_out;

  always #31 clk = ~clk;

  ili9341_rx #(.WIDTH(240), .HEIGHT(320)) dut (
    .clk_16MHz (clk),
    .rst       (rst),
    .ncs       (ncs),
    .cmd_data  (cmd_data),
    .write_edge(write_edge),
    .din       (din),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_data  (pix_data),
    .cmd_strobe(cmd_strobe),
    .last_cmd  (last_cmd),
    .display_on(display_on),
    .sleep_out (sleep_out)
  );

  int n_pass = 0, n_total = 0, n_fail = 0;

  // Observed pixel stream and command-strobe count.
  logic [33:0] q_dut[$];
  logic [33:0] q_exp[$];
  int          dut_cmds = 0;

  always @(negedge clk) begin
    if (pix_valid) q_dut.push_back({pix_x, pix_y, pix_data});
    if (cmd_strobe) dut_cmds++;
  end

  // Reference model: mode 0 ignores data, 1/2 gather window args, 3 writes pixels.
  int         m_sc, m_ec, m_sp, m_ep, m_cx, m_cy, m_mode, m_hi, m_cmds;
  int         m_args[$];
  bit         m_don, m_slp;
  logic [7:0] m_last;

  task automatic model_defaults();
    m_sc = 0; m_ec = 239; m_sp = 0; m_ep = 319;
  endtask

  task automatic model_reset();
    model_defaults();
    m_cx = 0; m_cy = 0; m_mode = 0; m_hi = -1;
    m_args.delete();
    m_don = 0; m_slp = 0; m_last = 8'h00;
  endtask

  task automatic model_byte(input bit cd, input logic [7:0] b);
    if (!cd) begin
      m_cmds++;
      m_last = b;
      m_args.delete();
      m_hi = -1;
      m_mode = 0;
      case (b)
        8'h2A: m_mode = 1;
        8'h2B: m_mode = 2;
        8'h2C: begin m_mode = 3; m_cx = m_sc; m_cy = m_sp; end
        8'h29: m_don = 1;
        8'h28: m_don = 0;
        8'h11: m_slp = 1;
        8'h10: m_slp = 0;
        8'h01: begin model_defaults(); m_don = 0; m_slp = 0; end
        default: ;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_args.push_back(int'(b));
      if (m_args.size() == 4) begin
        if (m_mode == 1) begin
          m_sc = ((m_args[0] << 8) | m_args[1]) & 511;
          m_ec = ((m_args[2] << 8) | m_args[3]) & 511;
        end else begin
          m_sp = ((m_args[0] << 8) | m_args[1]) & 511;
          m_ep = ((m_args[2] << 8) | m_args[3]) & 511;
        end
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (m_hi < 0) m_hi = int'(b);
      else begin
        q_exp.push_back({9'(m_cx), 9'(m_cy), m_hi[7:0], b});
        m_hi = -1;
        if (m_cx >= m_ec) begin
          m_cx = m_sc;
          m_cy = (m_cy >= m_ep) ? m_sp : m_cy + 1;
        end else m_cx = m_cx + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit cd, input logic [7:0] b, input bit cs = 1'b0, input int hold = 1);
    @(negedge clk);
    ncs = cs; cmd_data = cd; din = b; write_edge = 1'b1;
    repeat (hold) @(negedge clk);
    write_edge = 1'b0; ncs = 1'b0;
    if (!cs) model_byte(cd, b);
  endtask

  task automatic send_win(input logic [7:0] cmd, input int s, input int e, input logic [7:0] junk);
    logic [15:0] sv, ev;
    sv = 16'(s); ev = 16'(e);
    send(0, cmd);
    send(1, {junk[7:1], sv[8]}); send(1, sv[7:0]);
    send(1, {junk[6:0], ev[8]}); send(1, ev[7:0]);
  endtask

  task automatic send_pix(input logic [15:0] p);
    send(1, p[15:8]);
    send(1, p[7:0]);
  endtask

  task automatic check_pix(input string tag);
    int n;
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, 64'(q_dut.size()), 64'(q_exp.size()));
    n = (q_dut.size() < q_exp.size()) ? q_dut.size() : q_exp.size();
    for (int i = 0; i < n; i++) chk({tag, "_pix"}, 64'(q_dut[i]), 64'(q_exp[i]));
    q_dut.delete();
    q_exp.delete();
  endtask

  int sc, ec, sp, ep, npix;
  logic [7:0] junk;

  initial begin
    m_cmds = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_pix_valid", 64'(pix_valid), 0);
    chk("rst_pix_x", 64'(pix_x), 0);
    chk("rst_pix_y", 64'(pix_y), 0);
    chk("rst_pix_data", 64'(pix_data), 0);
    chk("rst_cmd_strobe", 64'(cmd_strobe), 0);
    chk("rst_last_cmd", 64'(last_cmd), 0);
    chk("rst_display_on", 64'(display_on), 0);
    chk("rst_sleep_out", 64'(sleep_out), 0);

    // First pixel after reset lands at the origin; pulses last exactly one cycle.
    send(0, 8'h2C);
    chk("cmd_strobe_hi", 64'(cmd_strobe), 1);
    chk("last_cmd_2c", 64'(last_cmd), 64'h2C);
    send(1, 8'hF8);
    chk("cmd_strobe_lo", 64'(cmd_strobe), 0);
    chk("pv_after_hi", 64'(pix_valid), 0);
    send(1, 8'h00);
    chk("pv_pulse", 64'(pix_valid), 1);
    chk("first_pix", 64'({pix_x, pix_y, pix_data}), 64'({9'd0, 9'd0, 16'hF800}));
    @(negedge clk);
    chk("pv_one_cycle", 64'(pix_valid), 0);
    check_pix("first");

    // Small 2x2 window, both axes wrap.
    send_win(8'h2A, 10, 11, 8'h00);
    send_win(8'h2B, 5, 6, 8'h00);
    send(0, 8'h2C);
    for (int i = 0; i < 5; i++) send_pix(16'(16'h1000 + i));
    chk("win_hold_x", 64'(pix_x), 10);
    chk("win_hold_y", 64'(pix_y), 5);
    check_pix("window");

    // Full-width strip at the bottom of the panel.
    send_win(8'h2A, 0, 239, 8'h00);
    send_win(8'h2B, 317, 319, 8'h00);
    send(0, 8'h2C);
    for (int i = 0; i < 721; i++) send_pix(16'($urandom));
    repeat (3) @(negedge clk);
    chk("strip_last_xy", (q_dut.size() >= 720) ? 64'(q_dut[719][33:16]) : 64'hDEAD, 64'({9'd239, 9'd319}));
    chk("strip_wrap_xy", 64'({pix_x, pix_y}), 64'({9'd0, 9'd317}));
    check_pix("strip");

    // A command between hi and lo bytes drops the pixel; data needs a new RAMWR.
    send(0, 8'h2C);
    send(1, 8'hAB);
    send(0, 8'h29);
    chk("abort_display_on", 64'(display_on), 1);
    send_pix(16'h1234);
    check_pix("abort");
    send(0, 8'h2C);
    send_pix(16'h5678);
    check_pix("abort_resume");

    // Truncated CASET leaves the window alone; ncs-masked and held strobes.
    send(0, 8'h01);
    send(0, 8'h2A);
    send(1, 8'h00); send(1, 8'h33); send(1, 8'h00);
    send(0, 8'h2C);
    send(1, 8'h77, 1'b1);
    send(1, 8'h9A, 1'b0, 4);
    send(1, 8'hBC);
    chk("trunc_caset_pix", 64'({pix_x, pix_y, pix_data}), 64'({9'd0, 9'd0, 16'h9ABC}));
    check_pix("trunc");

    // Reset between hi and lo bytes.
    send(0, 8'h11);
    send(0, 8'h2C);
    send(1, 8'hEE);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_sleep", 64'(sleep_out), 0);
    chk("rst_mid_pv", 64'(pix_valid), 0);
    send(1, 8'h11);
    check_pix("rst_mid");
    send(0, 8'h29);
    send(0, 8'h11);
    send_win(8'h2A, 50, 60, 8'h00);
    send(0, 8'h01);
    chk("swreset_don", 64'(display_on), 0);
    chk("swreset_slp", 64'(sleep_out), 0);
    send(0, 8'h2C);
    send_pix(16'hCAFE);
    check_pix("swreset");

    // Randomized windows, truncation junk, and mid-stream interruptions.
    for (int it = 0; it < 8; it++) begin
      sc = $urandom_range(0, 235); ec = sc + $urandom_range(0, 4);
      sp = $urandom_range(0, 315); ep = sp + $urandom_range(0, 4);
      junk = 8'($urandom);
      send_win(8'h2A, sc, ec, junk);
      send_win(8'h2B, sp, ep, 8'($urandom));
      send(0, 8'h2C);
      npix = $urandom_range(1, 25);
      for (int j = 0; j < npix; j++) begin
        send_pix(16'($urandom));
        if (j == npix / 2 && it[0]) begin
          send(1, 8'($urandom));
          send(0, (it[1]) ? 8'h28 : 8'h10);
          send(1, 8'($urandom));
          send(0, 8'h2C);
        end
      end
      check_pix("rand");
      chk("rand_display_on", 64'(display_on), 64'(m_don));
      chk("rand_sleep_out", 64'(sleep_out), 64'(m_slp));
    end

    chk("cmd_count", 64'(dut_cmds), 64'(m_cmds));
    chk("last_cmd_final", 64'(last_cmd), 64'(m_last));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
